// File: rtl/round_sequencer.sv
`timescale 1ns/1ps
// round_sequencer
//   Top-level round scheduler for the NOT-NOT reaction game. Each round it
//   requests an instruction, arms the judge and runs an answer deadline
//   counted in ticks. It then applies the verdict to score, level and lives,
//   and holds a feedback window before the next round. The deadline shrinks
//   as the level rises. The sequencer parks in OVER when the lives run out.
//
// Ports
//   clk, rst_n     clock; synchronous active-low reset
//   start          begin/restart a game (only honoured in IDLE and OVER)
//   tick           one-cycle timebase strobe; all timing counts ticks
//   instr_ack      instruction generator has loaded a new instruction
//   verdict_valid  one-cycle pulse from judge, qualifies verdict_ok
//   verdict_ok     1 = correct answer
//   instr_req      request for a new instruction, held until instr_ack
//   judge_arm      one-cycle pulse telling the judge to accept the next key
//   round_active   high while waiting for the answer
//   feedback_ok    high during feedback after a correct answer
//   feedback_bad   high during feedback after a wrong answer or timeout
//   timed_out      one-cycle pulse when the round expired
//   score          correct answers this game (saturating)
//   level          current level (saturating at 15)
//   lives          remaining lives
//   game_over      high in OVER
module round_sequencer #(
  parameter int LIFE_W         = 3,
  parameter int LIVES_INIT     = 3,
  parameter int SCORE_W        = 8,
  parameter int TMR_W          = 8,
  parameter int TIMEOUT_INIT   = 50,
  parameter int TIMEOUT_MIN    = 10,
  parameter int TIMEOUT_STEP   = 5,
  parameter int LEVEL_EVERY    = 4,
  parameter int FEEDBACK_TICKS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tick,
  input  logic               instr_ack,
  input  logic               verdict_valid,
  input  logic               verdict_ok,
  output logic               instr_req,
  output logic               judge_arm,
  output logic               round_active,
  output logic               feedback_ok,
  output logic               feedback_bad,
  output logic               timed_out,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic [LIFE_W-1:0]  lives,
  output logic               game_over
);

  // A zero-length feedback window or level period would never terminate,
  // so both are clamped to at least one.
  localparam int FB_LOAD   = (FEEDBACK_TICKS < 1) ? 1 : FEEDBACK_TICKS;
  localparam int FB_W      = $clog2(FB_LOAD + 1);
  localparam int LVL_EVERY = (LEVEL_EVERY < 1) ? 1 : LEVEL_EVERY;
  localparam int LVL_W     = $clog2(LVL_EVERY + 1);

  localparam logic [LIFE_W-1:0] LIVES_LOAD = LIFE_W'(LIVES_INIT);
  localparam logic [TMR_W-1:0]  TO_INIT    = TMR_W'(TIMEOUT_INIT);
  localparam logic [TMR_W-1:0]  TO_MIN     = TMR_W'(TIMEOUT_MIN);
  localparam logic [TMR_W-1:0]  TO_STEP    = TMR_W'(TIMEOUT_STEP);
  localparam logic [FB_W-1:0]   FB_LOAD_V  = FB_W'(FB_LOAD);
  localparam logic [LVL_W-1:0]  LVL_TOP    = LVL_W'(LVL_EVERY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT_ANS,
    S_RESULT,
    S_FEEDBACK,
    S_OVER
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   cur_timeout;
  logic [TMR_W-1:0]   timer;
  logic [FB_W-1:0]    fb_cnt;
  logic [LVL_W-1:0]   lvl_cnt;
  logic               last_ok;
  logic               timo;

  logic [TMR_W-1:0]   arm_load;
  logic [LVL_W-1:0]   lvl_inc;
  logic               tmr_expire;
  logic               fb_last;

  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [3:0] sat_inc_level(input logic [3:0] v);
    return (&v) ? v : v + 4'd1;
  endfunction

  function automatic logic [LIFE_W-1:0] sat_dec_lives(input logic [LIFE_W-1:0] v);
    return (v == '0) ? v : v - LIFE_W'(1);
  endfunction

  // max(TIMEOUT_MIN, cur - TIMEOUT_STEP), compared one bit wider so the
  // subtraction is only taken when it cannot wrap.
  function automatic logic [TMR_W-1:0] shrink_timeout(input logic [TMR_W-1:0] cur);
    logic [TMR_W:0] floor_plus_step;
    floor_plus_step = {1'b0, TO_MIN} + {1'b0, TO_STEP};
    if ({1'b0, cur} >= floor_plus_step) return cur - TO_STEP;
    return TO_MIN;
  endfunction

  // A zero deadline is run as one tick so the round still expires.
  assign arm_load   = (cur_timeout == '0) ? TMR_W'(1) : cur_timeout;
  assign lvl_inc    = lvl_cnt + LVL_W'(1);
  assign tmr_expire = tick && (timer <= TMR_W'(1));
  assign fb_last    = tick && (fb_cnt <= FB_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    instr_req    = 1'b0;
    judge_arm    = 1'b0;
    round_active = 1'b0;
    feedback_ok  = 1'b0;
    feedback_bad = 1'b0;
    timed_out    = 1'b0;
    game_over    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        instr_req = 1'b1;
        if (instr_ack) state_nxt = S_ARM;
      end
      S_ARM: begin
        judge_arm = 1'b1;
        state_nxt = S_WAIT_ANS;
      end
      S_WAIT_ANS: begin
        round_active = 1'b1;
        // A verdict arriving on the expiring tick still lands here first.
        if (verdict_valid || tmr_expire) state_nxt = S_RESULT;
      end
      S_RESULT: begin
        timed_out = timo;
        state_nxt = S_FEEDBACK;
      end
      S_FEEDBACK: begin
        feedback_ok  = last_ok;
        feedback_bad = ~last_ok;
        if (fb_last) state_nxt = (lives == '0) ? S_OVER : S_ISSUE;
      end
      S_OVER: begin
        game_over = 1'b1;
        if (start) state_nxt = S_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score       <= '0;
      level       <= '0;
      lives       <= LIVES_LOAD;
      cur_timeout <= TO_INIT;
      timer       <= '0;
      fb_cnt      <= '0;
      lvl_cnt     <= '0;
      last_ok     <= 1'b0;
      timo        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            score       <= '0;
            level       <= '0;
            lvl_cnt     <= '0;
            lives       <= LIVES_LOAD;
            cur_timeout <= TO_INIT;
          end
        end
        S_ARM: timer <= arm_load;
        S_WAIT_ANS: begin
          if (verdict_valid) begin
            last_ok <= verdict_ok;
            timo    <= 1'b0;
          end else if (tmr_expire) begin
            last_ok <= 1'b0;
            timo    <= 1'b1;
          end else if (tick) begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_RESULT: begin
          if (last_ok) begin
            score <= sat_inc_score(score);
            if (lvl_inc == LVL_TOP) begin
              lvl_cnt     <= '0;
              level       <= sat_inc_level(level);
              cur_timeout <= shrink_timeout(cur_timeout);
            end else begin
              lvl_cnt <= lvl_inc;
            end
          end else begin
            lives <= sat_dec_lives(lives);
          end
          fb_cnt <= FB_LOAD_V;
        end
        S_FEEDBACK: begin
          if (tick) fb_cnt <= fb_cnt - FB_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Top-level round scheduler for the NOT-NOT reaction game.
- Sequences each round: requests a new instruction, arms the judge unit, and runs a per-round answer deadline on a shared tick timebase.
- Consumes the judge verdict, updates score, level and lives, and holds a feedback window before the next round.
- Shrinks the answer deadline as the player levels up; stops in a game-over state when lives reach 0.

Parameters:
- LIFE_W, 3, width of lives counter
- LIVES_INIT, 3, lives loaded at game start
- SCORE_W, 8, width of score counter
- TMR_W, 8, width of deadline timer and timeout registers
- TIMEOUT_INIT, 50, ticks allowed per round at level 0
- TIMEOUT_MIN, 10, floor for the per-round deadline
- TIMEOUT_STEP, 5, deadline reduction per level
- LEVEL_EVERY, 4, consecutive-or-not correct answers per level-up
- FEEDBACK_TICKS, 8, ticks the feedback window lasts

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: rst_n, synchronous, active-low; clock clk
- start  in  1  begin/restart game; sampled only in IDLE and OVER
- tick  in  1  1-cycle timebase strobe; all timing counts ticks, not cycles
- instr_ack  in  1  instruction generator has loaded a new instruction
- verdict_valid  in  1  1-cycle pulse from judge: verdict_ok is valid
- verdict_ok  in  1  1 = correct answer
- instr_req  out  1  request new instruction; held until instr_ack
- judge_arm  out  1  1-cycle pulse: judge must accept the next key
- round_active  out  1  high in WAIT_ANS
- feedback_ok  out  1  high during FEEDBACK after a correct answer
- feedback_bad  out  1  high during FEEDBACK after a wrong answer or timeout
- timed_out  out  1  1-cycle pulse in RESULT when the round expired
- score  out  SCORE_W  correct answers this game
- level  out  4  current level
- lives  out  LIFE_W  remaining lives
- game_over  out  1  high in OVER

Behaviour:
- Reset state is IDLE.
- Reset values: instr_req=0, judge_arm=0, round_active=0, feedback_ok=0, feedback_bad=0, timed_out=0, score=0, level=0, lives=LIVES_INIT, game_over=0, cur_timeout=TIMEOUT_INIT, timer=0, fb_cnt=0, lvl_cnt=0, last_ok=0.
- Reset mid-game takes effect the next edge and overrides everything.
- All control outputs are Moore outputs decoded from the state register.
- IDLE:
  - start=1 loads score=0, level=0, lvl_cnt=0, lives=LIVES_INIT, cur_timeout=TIMEOUT_INIT, and moves to ISSUE.
- ISSUE:
  - instr_req=1.
  - instr_ack=1 moves to ARM. Otherwise stay; there is no timeout here.
- ARM (one cycle):
  - judge_arm=1, timer<=cur_timeout, then WAIT_ANS.
- WAIT_ANS:
  - round_active=1.
  - verdict_valid=1 latches last_ok<=verdict_ok, timo<=0, goes to RESULT.
  - Otherwise, on tick with timer==1: last_ok<=0, timo<=1, go to RESULT.
  - Otherwise, on tick: timer decrements.
  - The deadline is exactly cur_timeout ticks.
  - verdict_valid and the expiring tick in the same cycle: the verdict wins.
  - verdict_valid in any other state is ignored.
- RESULT (one cycle):
  - timed_out=timo.
  - If last_ok: score+1 (saturates at all-ones) and lvl_cnt+1.
  - If lvl_cnt reaches LEVEL_EVERY: lvl_cnt<=0, level+1 (saturates at 15), and cur_timeout<=max(TIMEOUT_MIN, cur_timeout-TIMEOUT_STEP). The subtraction is computed without underflow.
  - If not last_ok: lives-1 (saturates at 0).
  - fb_cnt<=FEEDBACK_TICKS, then FEEDBACK.
- FEEDBACK:
  - feedback_ok=last_ok, feedback_bad=~last_ok.
  - fb_cnt decrements on tick.
  - On the tick where fb_cnt==1: go to OVER if lives==0, else ISSUE.
  - FEEDBACK_TICKS=0 is treated as 1.
- OVER:
  - game_over=1; score, level and lives hold.
  - start=1 performs the same load as IDLE and goes to ISSUE.
- start outside IDLE/OVER is ignored.
- instr_ack outside ISSUE is ignored.

Test Plan:
Common setup for all scenarios: LIVES_INIT=3, TIMEOUT_INIT=4, TIMEOUT_MIN=2, TIMEOUT_STEP=1, LEVEL_EVERY=2, FEEDBACK_TICKS=2, tick=1 every cycle unless stated.
- Basic round: reset, start pulse, instr_ack 2 cycles after instr_req rises, verdict_valid=1/ok=1 in 2nd WAIT_ANS cycle -> judge_arm pulses once, score=1, lives=3, feedback_ok high 2 cycles, instr_req reasserts.
- Timeout: no verdict -> round_active high exactly 4 cycles, timed_out pulses, lives 3->2, feedback_bad high 2 cycles.
- Tie: verdict_valid ok=1 on the same cycle timer==1 expires -> counted correct, timed_out=0, lives unchanged.
- Level-up: 4 correct rounds -> level 0->1->2, round_active window 4, 4, 3, 3 ticks, later rounds floored at 2 ticks.
- Game over and restart: 3 wrong verdicts -> lives=0, game_over=1, extra verdict_valid pulses ignored; start -> score=0, lives=3, level=0, instr_req=1.
- Tick gating and reset: tick every 3rd cycle stretches deadline to 12 cycles; rst_n=0 mid-WAIT_ANS -> next cycle IDLE, all outputs at reset values.
